stream_minmax_ctrl: RTL and testbench
=====================================

Name: stream_minmax_ctrl

Overview:
Sequences a shared unsigned magnitude comparator over a burst of operands to find the maximum and minimum of the burst, plus the index of each. A start command with a length opens a burst. Operands arrive on a valid/ready stream, and the result is held on a valid/ready output until it is consumed. The block sits between a data source (e.g. sample buffer) and downstream threshold/decision logic.

Parameters:
WIDTH, 32, operand width in bits (unsigned)
CNT_W, 8, width of burst length and index fields; max burst = 2^CNT_W - 1

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request to open a burst; honoured only in IDLE
len  in  CNT_W  number of operands in burst, sampled with start
in_data  in  WIDTH  operand
in_valid  in  1  operand valid
in_ready  out  1  block accepts operand; high only in ACCUM
busy  out  1  high in ACCUM and DONE
out_valid  out  1  result valid; high only in DONE
out_ready  in  1  downstream consumes result
max_val  out  WIDTH  largest operand of burst
min_val  out  WIDTH  smallest operand of burst
max_idx  out  CNT_W  index (0-based) of first occurrence of max
min_idx  out  CNT_W  index of first occurrence of min
empty  out  1  burst had len = 0; max/min/idx fields are 0

Behaviour:
- Reset (clk edge with rst=1): state IDLE; in_ready, busy, out_valid, empty = 0; max_val, min_val, max_idx, min_idx = 0; internal count = 0. rst overrides all other inputs, including mid-burst; a partial burst is discarded and no result is produced.
- States: IDLE, ACCUM, DONE.
- IDLE: start=1 and len!=0 -> ACCUM, latch len, clear count, clear empty. start=1 and len=0 -> DONE with empty=1 and all value/idx fields 0. start=0 -> stay.
- ACCUM: in_ready=1. Transfer = in_valid & in_ready.
  - First transfer (count=0): max_val=min_val=in_data, max_idx=min_idx=0.
  - Later transfers: comparator A = in_data vs max_val; max updates only on strictly greater. Comparator B = in_data vs min_val; min updates only on strictly lesser. Equal values never update, so the first occurrence wins. Index stored = current count.
  - count increments per transfer. The transfer at count = len-1 moves the block to DONE on the same edge; in_ready drops in the next cycle.
  - No transfer -> hold; no timeout.
- DONE: out_valid=1 and all result fields stable. out_valid & out_ready -> IDLE on that edge; result registers keep their values, and out_valid drops.
- start is ignored while busy (ACCUM/DONE); it is not queued.
- Latency: out_valid is asserted the cycle after the last operand is accepted. A len=0 burst asserts out_valid the cycle after start.
- Throughput: one operand per cycle. A back-to-back burst needs one IDLE cycle after consumption.
- All compares are unsigned, full WIDTH. count and len are CNT_W wide, with no wrap (len <= 2^CNT_W - 1).

Decomposition:
- Shared package: state encoding enum (IDLE=0, ACCUM=1, DONE=2), default WIDTH/CNT_W constants.
- Sub-module mag_cmp (parameter WIDTH; inputs a, b; outputs lesser, greater, equal; purely combinational). Instantiated twice (max path, min path). The controller contains only FSM, counter and result registers.

Test Plan:
- Reset then idle: rst 2 cycles -> all outputs 0, in_ready=0; start with len=0 -> next cycle out_valid=1, empty=1, fields 0.
- Basic burst: len=4, data 5,9,2,7 streamed back-to-back -> out_valid one cycle after 4th beat; max_val=9 idx=1, min_val=2 idx=2.
- Ties and extremes: len=5, data 32'hFFFFFFFF,0,32'hFFFFFFFF,0,3 -> max idx=0, min idx=1 (first occurrence kept).
- Stalls and backpressure: len=3, in_valid gaps between beats; out_ready held low 5 cycles -> result stable and out_valid held; consumed on out_ready=1, then IDLE; start asserted during ACCUM/DONE ignored.
- Single operand: len=1, data 42 -> max=min=42, both idx=0.
- Reset mid-burst: len=4, 2 beats accepted, rst=1 -> next cycle all outputs 0, IDLE; new burst len=2 (1,1) -> max=min=1, idx 0.

Source files
------------

// File: rtl/stream_minmax_ctrl_pkg.sv
// rtl/stream_minmax_ctrl_pkg.sv - shared state encoding and default sizes for stream_minmax_ctrl
package stream_minmax_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/stream_minmax_ctrl_mag_cmp.sv
// rtl/stream_minmax_ctrl_mag_cmp.sv - combinational unsigned magnitude comparator
module mag_cmp #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lesser,
  output logic             greater,
  output logic             equal
);

  // Unsigned full-width relation of a against b
  always_comb begin
    lesser  = (a < b);
    greater = (a > b);
    equal   = (a == b);
  end

endmodule

// File: rtl/stream_minmax_ctrl.sv
// rtl/stream_minmax_ctrl.sv - burst max/min finder sequencing two shared magnitude comparators
module stream_minmax_ctrl
  import stream_minmax_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [CNT_W-1:0] max_idx,
  output logic [CNT_W-1:0] min_idx,
  output logic             empty
);

  state_t           state, next_state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] count;
  logic             xfer;
  logic             last_beat;

  logic max_lt, max_gt, max_eq;
  logic min_lt, min_gt, min_eq;
  logic unused_cmp;

  // Max path only cares about strictly greater; min path only about strictly lesser
  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a       (in_data),
    .b       (max_val),
    .lesser  (max_lt),
    .greater (max_gt),
    .equal   (max_eq)
  );

  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a       (in_data),
    .b       (min_val),
    .lesser  (min_lt),
    .greater (min_gt),
    .equal   (min_eq)
  );

  assign unused_cmp = ^{max_lt, max_eq, min_gt, min_eq};

  assign xfer      = in_valid & in_ready;
  assign last_beat = (count == len_q - 1'b1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs decoded from the current state
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (len == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_beat) begin
          next_state = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Burst length, beat counter and result registers; results persist after consumption
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      count   <= '0;
      empty   <= 1'b0;
      max_val <= '0;
      min_val <= '0;
      max_idx <= '0;
      min_idx <= '0;
    end else if (state == IDLE && start) begin
      count <= '0;
      if (len == '0) begin
        empty   <= 1'b1;
        max_val <= '0;
        min_val <= '0;
        max_idx <= '0;
        min_idx <= '0;
      end else begin
        empty <= 1'b0;
        len_q <= len;
      end
    end else if (state == ACCUM && xfer) begin
      count <= count + 1'b1;
      if (count == '0) begin
        max_val <= in_data;
        min_val <= in_data;
        max_idx <= '0;
        min_idx <= '0;
      end else begin
        if (max_gt) begin
          max_val <= in_data;
          max_idx <= count;
        end
        if (min_lt) begin
          min_val <= in_data;
          min_idx <= count;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_minmax_ctrl.sv
// tb/tb_stream_minmax_ctrl.sv - directed self-checking bench for stream_minmax_ctrl
module tb_stream_minmax_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] max_val;
  logic [31:0] min_val;
  logic [7:0]  max_idx;
  logic [7:0]  min_idx;
  logic        empty;

  int vectors;
  int miscompares;

  logic [31:0] vec [0:7];
  logic [79:0] res;
  logic [2:0]  hs;

  stream_minmax_ctrl #(.WIDTH(32), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .max_val   (max_val),
    .min_val   (min_val),
    .max_idx   (max_idx),
    .min_idx   (min_idx),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign res = {max_val, max_idx, min_val, min_idx};
  assign hs  = {in_ready, busy, out_valid};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_burst(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = vec[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({hs, empty} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got %b exp 0000", {hs, empty});
    end
    vectors++;
    if (res !== 80'd0) begin
      miscompares++;
      $display("FAIL reset_fields got %h exp 0", res);
    end
    open_burst(8'd0);
    vectors++;
    if ({hs, empty} !== 4'b0111) begin
      miscompares++;
      $display("FAIL empty_flags got %b exp 0111", {hs, empty});
    end
    vectors++;
    if (res !== 80'd0) begin
      miscompares++;
      $display("FAIL empty_fields got %h exp 0", res);
    end
    consume();
    vectors++;
    if ({hs, empty} !== 4'b0001) begin
      miscompares++;
      $display("FAIL empty_consume got %b exp 0001", {hs, empty});
    end
  endtask

  task automatic test_basic();
    vec[0] = 32'd5; vec[1] = 32'd9; vec[2] = 32'd2; vec[3] = 32'd7;
    open_burst(8'd4);
    vectors++;
    if ({hs, empty} !== 4'b1100) begin
      miscompares++;
      $display("FAIL basic_open got %b exp 1100", {hs, empty});
    end
    feed(3);
    vectors++;
    if (hs !== 3'b110) begin
      miscompares++;
      $display("FAIL basic_before_last got %b exp 110", hs);
    end
    feed(0);
    in_valid = 1'b1;
    in_data  = vec[3];
    tick();
    in_valid = 1'b0;
    vectors++;
    if (hs !== 3'b011) begin
      miscompares++;
      $display("FAIL basic_latency got %b exp 011", hs);
    end
    vectors++;
    if (res !== {32'd9, 8'd1, 32'd2, 8'd2}) begin
      miscompares++;
      $display("FAIL basic_result got %h exp %h", res, {32'd9, 8'd1, 32'd2, 8'd2});
    end
    consume();
    vectors++;
    if (hs !== 3'b000) begin
      miscompares++;
      $display("FAIL basic_consume got %b exp 000", hs);
    end
  endtask

  task automatic test_ties();
    vec[0] = 32'hFFFFFFFF; vec[1] = 32'd0; vec[2] = 32'hFFFFFFFF;
    vec[3] = 32'd0;        vec[4] = 32'd3;
    open_burst(8'd5);
    feed(5);
    vectors++;
    if ({out_valid, res} !== {1'b1, 32'hFFFFFFFF, 8'd0, 32'd0, 8'd1}) begin
      miscompares++;
      $display("FAIL ties_result got %b %h exp 1 %h", out_valid, res, {32'hFFFFFFFF, 8'd0, 32'd0, 8'd1});
    end
    consume();
  endtask

  task automatic test_stall();
    open_burst(8'd3);
    in_valid = 1'b1; in_data = 32'd7; tick();
    in_valid = 1'b0;
    start = 1'b1; len = 8'd0;
    tick();
    tick();
    start = 1'b0;
    vectors++;
    if ({hs, empty} !== 4'b1100) begin
      miscompares++;
      $display("FAIL stall_gap got %b exp 1100", {hs, empty});
    end
    in_valid = 1'b1; in_data = 32'd3; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 32'd10; tick();
    in_valid = 1'b0;
    start = 1'b1; len = 8'd1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({hs, res} !== {3'b011, 32'd10, 8'd2, 32'd3, 8'd1}) begin
        miscompares++;
        $display("FAIL stall_hold%0d got %b %h exp 011 %h", i, hs, res, {32'd10, 8'd2, 32'd3, 8'd1});
      end
      tick();
    end
    start = 1'b0;
    consume();
    vectors++;
    if ({hs, res} !== {3'b000, 32'd10, 8'd2, 32'd3, 8'd1}) begin
      miscompares++;
      $display("FAIL stall_consume got %b %h exp 000 %h", hs, res, {32'd10, 8'd2, 32'd3, 8'd1});
    end
    tick();
    vectors++;
    if (hs !== 3'b000) begin
      miscompares++;
      $display("FAIL stall_no_queue got %b exp 000", hs);
    end
  endtask

  task automatic test_single();
    vec[0] = 32'd42;
    open_burst(8'd1);
    feed(1);
    vectors++;
    if ({hs, res} !== {3'b011, 32'd42, 8'd0, 32'd42, 8'd0}) begin
      miscompares++;
      $display("FAIL single_result got %b %h exp 011 %h", hs, res, {32'd42, 8'd0, 32'd42, 8'd0});
    end
    consume();
  endtask

  task automatic test_reset_mid();
    vec[0] = 32'd5; vec[1] = 32'd6;
    open_burst(8'd4);
    feed(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({hs, empty, res} !== {4'b0000, 80'd0}) begin
      miscompares++;
      $display("FAIL midrst_clear got %b %b %h exp 000 0 0", hs, empty, res);
    end
    vec[0] = 32'd1; vec[1] = 32'd1;
    open_burst(8'd2);
    feed(2);
    vectors++;
    if ({hs, res} !== {3'b011, 32'd1, 8'd0, 32'd1, 8'd0}) begin
      miscompares++;
      $display("FAIL midrst_newburst got %b %h exp 011 %h", hs, res, {32'd1, 8'd0, 32'd1, 8'd0});
    end
    consume();
  endtask

  task automatic test_max_len();
    open_burst(8'd255);
    for (int i = 0; i < 255; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i) ^ 32'h80;
      tick();
      if (i == 253) begin
        vectors++;
        if (hs !== 3'b110) begin
          miscompares++;
          $display("FAIL maxlen_early got %b exp 110", hs);
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if ({hs, res} !== {3'b011, 32'd255, 8'd127, 32'd0, 8'd128}) begin
      miscompares++;
      $display("FAIL maxlen_result got %b %h exp 011 %h", hs, res, {32'd255, 8'd127, 32'd0, 8'd128});
    end
    consume();
  endtask

  task automatic test_back_to_back();
    vec[0] = 32'd8; vec[1] = 32'd4;
    open_burst(8'd2);
    feed(2);
    consume();
    vec[0] = 32'd3; vec[1] = 32'd12; vec[2] = 32'd12;
    open_burst(8'd3);
    feed(3);
    vectors++;
    if ({hs, empty, res} !== {4'b0110, 32'd12, 8'd1, 32'd3, 8'd0}) begin
      miscompares++;
      $display("FAIL b2b_result got %b %b %h exp 011 0 %h", hs, empty, res, {32'd12, 8'd1, 32'd3, 8'd0});
    end
    consume();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    len         = 8'd0;
    in_data     = 32'd0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    test_reset();
    test_basic();
    test_ties();
    test_stall();
    test_single();
    test_reset_mid();
    test_max_len();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
